// File: rtl/round_key_sequencer_pkg.sv
// Shared AES parameters and the round key sequencer state encoding.
// Holds the byte width, state size, and round count defaults that the key
// scheduler also uses, plus the state enum for round_key_sequencer.
package round_key_sequencer_pkg;

  localparam int unsigned AES_NB_BYTE       = 8;
  localparam int unsigned AES_N_BYTES_STATE = 16;
  localparam int unsigned AES_N_ROUNDS      = 14;
  localparam int unsigned ROUND_IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2
  } rks_state_e;

endpackage

// File: rtl/round_key_sequencer.sv
// Round key sequencer: stores a full AES key schedule and serves one round key
// per cycle, from 0 up to N_ROUNDS, to the cipher core. The core consumes each
// key with an ack handshake.
// If a new schedule arrives mid-block, it is held as pending and captured when
// the block completes.
// Ports:
//   i_clock, i_reset_n   clock and synchronous active-low reset
//   i_valid              clock enable; everything holds while low
//   i_round_key_vector   full schedule, key r at [r*KEY_W +: KEY_W]
//   i_keys_ready         schedule-complete pulse from the key scheduler
//   i_start, i_key_ack   block request and per-key consume from the core
//   o_round_key/o_round_index/o_key_valid   current key, its index, valid flag
//   o_last_round         combinational: valid key is the final one
//   o_keys_loaded        store holds a complete schedule
//   o_block_done         one-enabled-cycle pulse after the final key is acked
// N_ROUNDS above 15 cannot be represented in o_round_index and is unsupported.
module round_key_sequencer
  import round_key_sequencer_pkg::*;
#(
  parameter int unsigned NB_BYTE       = AES_NB_BYTE,
  parameter int unsigned N_BYTES_STATE = AES_N_BYTES_STATE,
  parameter int unsigned N_ROUNDS      = AES_N_ROUNDS
) (
  input  logic                                            i_clock,
  input  logic                                            i_reset_n,
  input  logic                                            i_valid,
  input  logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1)-1:0]   i_round_key_vector,
  input  logic                                            i_keys_ready,
  input  logic                                            i_start,
  input  logic                                            i_key_ack,
  output logic [N_BYTES_STATE*NB_BYTE-1:0]                o_round_key,
  output logic [ROUND_IDX_W-1:0]                          o_round_index,
  output logic                                            o_key_valid,
  output logic                                            o_last_round,
  output logic                                            o_keys_loaded,
  output logic                                            o_block_done
);

  localparam int unsigned KEY_W = N_BYTES_STATE * NB_BYTE;
  localparam int unsigned VEC_W = KEY_W * (N_ROUNDS + 1);
  localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(N_ROUNDS);

  rks_state_e               state_q, state_d;
  logic                     pending_q, pending_d;
  logic [VEC_W-1:0]         key_store_q;
  logic                     store_we;
  logic [KEY_W-1:0]         round_key_d;
  logic [ROUND_IDX_W-1:0]   round_index_d;
  logic                     key_valid_d;
  logic                     keys_loaded_d;
  logic                     block_done_d;
  logic [ROUND_IDX_W-1:0]   next_index;

  assign next_index   = o_round_index + ROUND_IDX_W'(1);
  assign o_last_round = o_key_valid && (o_round_index == LAST_IDX);

  // Next-state and next-output logic; everything holds while i_valid is low.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    store_we      = 1'b0;
    round_key_d   = o_round_key;
    round_index_d = o_round_index;
    key_valid_d   = o_key_valid;
    keys_loaded_d = o_keys_loaded;
    block_done_d  = o_block_done;

    if (i_valid) begin
      block_done_d = 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (i_keys_ready) begin
            store_we      = 1'b1;
            keys_loaded_d = 1'b1;
            state_d       = ST_READY;
          end
        end
        ST_READY: begin
          if (i_keys_ready) begin
            store_we      = 1'b1;
            keys_loaded_d = 1'b1;
          end
          if (i_start) begin
            state_d       = ST_RUN;
            key_valid_d   = 1'b1;
            round_index_d = '0;
            // A schedule arriving in the same cycle supplies key 0 directly.
            round_key_d   = i_keys_ready ? i_round_key_vector[0 +: KEY_W]
                                         : key_store_q[0 +: KEY_W];
          end
        end
        ST_RUN: begin
          if (i_keys_ready) begin
            pending_d = 1'b1;
          end
          if (i_key_ack) begin
            if (o_round_index < LAST_IDX) begin
              round_index_d = next_index;
              round_key_d   = key_store_q[next_index*KEY_W +: KEY_W];
            end else begin
              state_d      = ST_READY;
              key_valid_d  = 1'b0;
              block_done_d = 1'b1;
              // Deferred schedule is taken from the vector on the exit cycle.
              if (pending_q || i_keys_ready) begin
                store_we = 1'b1;
              end
              pending_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q       <= ST_EMPTY;
      pending_q     <= 1'b0;
      o_round_key   <= '0;
      o_round_index <= '0;
      o_key_valid   <= 1'b0;
      o_keys_loaded <= 1'b0;
      o_block_done  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      o_round_key   <= round_key_d;
      o_round_index <= round_index_d;
      o_key_valid   <= key_valid_d;
      o_keys_loaded <= keys_loaded_d;
      o_block_done  <= block_done_d;
    end
  end

  // Key store; not cleared by reset, o_keys_loaded tracks its validity.
  always_ff @(posedge i_clock) begin
    if (i_reset_n && store_we) begin
      key_store_q <= i_round_key_vector;
    end
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Self-checking bench for round_key_sequencer: a constant vector table, hand
// sequences for the multi-cycle corner cases, and random stimulus checked
// against a transaction-level model of the key service.
module tb_round_key_sequencer;

  localparam int unsigned NR = 14;
  localparam int unsigned KW = 128;
  localparam int unsigned VW = KW * (NR + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          kr = 1'b0;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  logic [VW-1:0] vec = '0;
  logic [KW-1:0] o_round_key;
  logic [3:0]    o_round_index;
  logic          o_key_valid, o_last_round, o_keys_loaded, o_block_done;

  always #5 clk = ~clk;

  round_key_sequencer dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_valid            (valid),
    .i_round_key_vector (vec),
    .i_keys_ready       (kr),
    .i_start            (start),
    .i_key_ack          (ack),
    .o_round_key        (o_round_key),
    .o_round_index      (o_round_index),
    .o_key_valid        (o_key_valid),
    .o_last_round       (o_last_round),
    .o_keys_loaded      (o_keys_loaded),
    .o_block_done       (o_block_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stored schedule plus "serving a block" status.
  logic [KW-1:0] m_store [NR+1];
  bit            m_loaded, m_busy, m_pending, m_done;
  int            m_idx;
  logic [KW-1:0] m_key;

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [KW-1:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic set_pattern(input logic [7:0] base);
    for (int r = 0; r <= NR; r++) vec[r*KW +: KW] = pat(8'(base + 8'(r)));
  endtask

  task automatic set_random();
    for (int w = 0; w < VW/32; w++) vec[w*32 +: 32] = $urandom;
  endtask

  task automatic capture();
    for (int r = 0; r <= NR; r++) m_store[r] = vec[r*KW +: KW];
  endtask

  task automatic model_step();
    bit can_start;
    if (!rst_n) begin
      m_busy = 0; m_pending = 0; m_done = 0; m_loaded = 0; m_idx = 0; m_key = '0;
    end else if (valid) begin
      m_done = 0;
      if (!m_busy) begin
        can_start = m_loaded;
        if (kr) begin capture(); m_loaded = 1; end
        if (start && can_start) begin
          m_busy = 1; m_idx = 0; m_key = m_store[0];
        end
      end else begin
        if (kr) m_pending = 1;
        if (ack) begin
          if (m_idx < NR) begin
            m_idx++; m_key = m_store[m_idx];
          end else begin
            m_busy = 0; m_done = 1;
            if (m_pending) capture();
            m_pending = 0;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model_valid",  KW'(o_key_valid),   KW'(m_busy));
    chk("model_index",  KW'(o_round_index), KW'(m_idx));
    chk("model_key",    o_round_key,        m_key);
    chk("model_last",   KW'(o_last_round),  KW'(m_busy && m_idx == NR));
    chk("model_done",   KW'(o_block_done),  KW'(m_done));
    chk("model_loaded", KW'(o_keys_loaded), KW'(m_loaded));
  endtask

  task automatic tick(input logic r, input logic v, input logic k, input logic s, input logic a);
    @(negedge clk);
    rst_n = r; valid = v; kr = k; start = s; ack = a;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst_n, valid, kr, start, ack;
    logic       e_kv;
    logic [3:0] e_idx;
    logic       e_last, e_done, e_loaded;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int  exp_idx;
    int  step;
    bit  fin;
    bit  v, a;

    tbl[0]  = '{0,1,0,0,0, 0,4'd0,0,0,0};  // reset
    tbl[1]  = '{1,1,0,1,0, 0,4'd0,0,0,0};  // start ignored while empty
    tbl[2]  = '{1,1,1,0,0, 0,4'd0,0,0,1};  // schedule loaded
    tbl[3]  = '{1,1,0,0,1, 0,4'd0,0,0,1};  // ack ignored without a valid key
    tbl[4]  = '{1,0,0,1,0, 0,4'd0,0,0,1};  // start while disabled
    tbl[5]  = '{1,1,0,1,0, 1,4'd0,0,0,1};  // block starts at key 0
    tbl[6]  = '{1,1,0,0,1, 1,4'd1,0,0,1};
    tbl[7]  = '{1,1,0,0,0, 1,4'd1,0,0,1};  // no ack: hold
    tbl[8]  = '{1,0,0,0,1, 1,4'd1,0,0,1};  // ack while disabled: hold
    tbl[9]  = '{1,1,0,1,1, 1,4'd2,0,0,1};  // start ignored in a block
    tbl[10] = '{1,1,0,0,0, 1,4'd2,0,0,1};
    tbl[11] = '{0,0,0,0,1, 0,4'd0,0,0,0};  // reset regardless of enable
    tbl[12] = '{1,1,0,0,0, 0,4'd0,0,0,0};

    set_pattern(8'h00);
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].rst_n, tbl[i].valid, tbl[i].kr, tbl[i].start, tbl[i].ack);
      chk($sformatf("tbl%0d_valid", i),  KW'(o_key_valid),   KW'(tbl[i].e_kv));
      chk($sformatf("tbl%0d_index", i),  KW'(o_round_index), KW'(tbl[i].e_idx));
      chk($sformatf("tbl%0d_last", i),   KW'(o_last_round),  KW'(tbl[i].e_last));
      chk($sformatf("tbl%0d_done", i),   KW'(o_block_done),  KW'(tbl[i].e_done));
      chk($sformatf("tbl%0d_loaded", i), KW'(o_keys_loaded), KW'(tbl[i].e_loaded));
      if (tbl[i].e_kv) chk($sformatf("tbl%0d_key", i), o_round_key, pat(8'(tbl[i].e_idx)));
    end

    // Full block with ack held high: one key per cycle.
    tick(1,1,1,0,0);
    chk("a_loaded", KW'(o_keys_loaded), KW'(1));
    tick(1,1,0,1,0);
    chk("a_key0", o_round_key, pat(8'h00));
    for (int i = 1; i <= 14; i++) begin
      tick(1,1,0,0,1);
      chk("a_index", KW'(o_round_index), KW'(i));
      chk("a_key",   o_round_key,        pat(8'(i)));
      chk("a_last",  KW'(o_last_round),  KW'(i == 14));
    end
    tick(1,1,0,0,1);
    chk("a_done",  KW'(o_block_done), KW'(1));
    chk("a_valid", KW'(o_key_valid),  KW'(0));
    tick(1,1,0,0,0);
    chk("a_done_clr", KW'(o_block_done), KW'(0));

    // Ack and enable toggling: held keys stay stable, no skips.
    tick(1,1,0,1,0);
    exp_idx = 0; step = 0; fin = 0;
    chk("b_key0", o_round_key, pat(8'h00));
    while (!fin && step < 200) begin
      v = (step % 3) != 2;
      a = (step % 2) == 0;
      tick(1, v, 0, 0, a);
      if (v && a) begin
        if (exp_idx == 14) fin = 1;
        else exp_idx++;
      end
      if (fin) begin
        chk("b_done", KW'(o_block_done), KW'(1));
      end else begin
        chk("b_index", KW'(o_round_index), KW'(exp_idx));
        chk("b_key",   o_round_key,        pat(8'(exp_idx)));
      end
      step++;
    end
    chk("b_finished", KW'(fin), KW'(1));
    tick(1,0,0,0,0);
    chk("b_done_hold", KW'(o_block_done), KW'(1));
    tick(1,1,0,0,0);
    chk("b_done_once", KW'(o_block_done), KW'(0));

    // New schedule mid-block: old keys finish, next block uses new ones.
    tick(1,1,0,1,0);
    for (int i = 1; i <= 5; i++) tick(1,1,0,0,1);
    set_pattern(8'hA0);
    tick(1,1,1,0,0);
    chk("c_key5_old", o_round_key, pat(8'h05));
    for (int i = 6; i <= 14; i++) begin
      tick(1,1,0,0,1);
      chk("c_key_old", o_round_key, pat(8'(i)));
    end
    tick(1,1,0,0,1);
    chk("c_done", KW'(o_block_done), KW'(1));
    tick(1,1,0,1,0);
    chk("c_new_key0", o_round_key, pat(8'hA0));
    tick(1,1,0,0,1);
    chk("c_new_key1", o_round_key, pat(8'hA1));
    for (int i = 2; i <= 15; i++) tick(1,1,0,0,1);
    chk("c_done2", KW'(o_block_done), KW'(1));

    // Reset in the middle of a block.
    tick(1,1,0,1,0);
    for (int i = 1; i <= 7; i++) tick(1,1,0,0,1);
    chk("d_index7", KW'(o_round_index), KW'(7));
    tick(0,1,0,0,1);
    chk("d_valid",  KW'(o_key_valid),   KW'(0));
    chk("d_done",   KW'(o_block_done),  KW'(0));
    chk("d_loaded", KW'(o_keys_loaded), KW'(0));
    tick(1,1,0,0,1);
    chk("d_done_after", KW'(o_block_done), KW'(0));
    tick(1,1,0,1,0);
    chk("d_start_empty", KW'(o_key_valid), KW'(0));

    // Simultaneous keys_ready and start while ready.
    tick(1,1,1,0,0);
    set_pattern(8'hC0);
    tick(1,1,1,1,0);
    chk("e_valid", KW'(o_key_valid), KW'(1));
    chk("e_key0",  o_round_key,      pat(8'hC0));
    for (int i = 1; i <= 15; i++) tick(1,1,0,0,1);
    chk("e_done", KW'(o_block_done), KW'(1));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic rr, vv, kk, ss, aa;
      rr = ($urandom_range(0, 99) != 0);
      vv = ($urandom_range(0, 3) != 0);
      kk = ($urandom_range(0, 19) == 0);
      ss = ($urandom_range(0, 5) == 0);
      aa = ($urandom_range(0, 1) == 1);
      if (kk || $urandom_range(0, 9) == 0) set_random();
      tick(rr, vv, kk, ss, aa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
